// File: rtl/filter_pkg.sv
// Shared constants, FSM state type and output saturation for the FIR
// low-pass filter used in the audio effects path.
//   TAPS_DEF      default tap count / delay-line depth
//   COEF_W        coefficient width, signed Q1.15
//   ACC_W         accumulator width, signed
//   FILTER_COEFFS packed coefficient table, tap k at [k*COEF_W +: COEF_W]
//   state_e       FSM states of filter_ctrl
//   saturate16    Q1.15 rescale of the accumulator with clamp to 16 bits
package filter_pkg;

  localparam int TAPS_DEF = 8;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int PROD_W   = 32;
  localparam int ACC_W    = 40;

  // Moving average: 0.125 on every tap.
  localparam logic [TAPS_DEF*COEF_W-1:0] FILTER_COEFFS = {TAPS_DEF{16'h1000}};

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Arithmetic shift floors toward -inf, so -1/32768 stays -1 (16'hFFFF).
  function automatic logic [DATA_W-1:0] saturate16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] w_shr;
    w_shr = acc >>> 15;
    if (w_shr > SAT_MAX) begin
      return 16'h7FFF;
    end
    if (w_shr < SAT_MIN) begin
      return 16'h8000;
    end
    return w_shr[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/filter_if.sv
// Sample interface between the codec side and the filter.
//   sample_end    pulse: audio_input carries a new sample
//   sample_req    pulse: DAC wants the next filtered sample
//   audio_input   signed 16-bit input sample
//   audio_output  signed 16-bit filtered sample (registered in the filter)
interface filter_if;
  import filter_pkg::*;

  logic              sample_end;
  logic              sample_req;
  logic [DATA_W-1:0] audio_input;
  logic [DATA_W-1:0] audio_output;

  modport master (
    output sample_end,
    output sample_req,
    output audio_input,
    input  audio_output
  );

  modport slave (
    input  sample_end,
    input  sample_req,
    input  audio_input,
    output audio_output
  );

endinterface

// File: rtl/filter_mac.sv
// Signed multiply-accumulate: one 16x16 product per enabled cycle added
// into a sign-extended ACC_W accumulator.
//   audio_clk  clock, rising edge
//   reset      async active-low reset, clears the accumulator
//   i_clr      synchronous clear (wins over i_en)
//   i_en       accumulate this cycle
//   i_sample   signed delay-line tap
//   i_coef     signed Q1.15 coefficient
//   o_acc      accumulator value
module filter_mac
  import filter_pkg::*;
(
  input  logic                     audio_clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = PROD_W'(i_sample) * PROD_W'(i_coef);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/filter_ctrl.sv
// Fixed-coefficient FIR low-pass filter. Each accepted sample is shifted
// into the delay line, then one tap per cycle is multiplied and
// accumulated; the rescaled, saturated result is handed to the DAC on
// its next request.
//   audio_clk  clock, rising edge
//   reset      async active-low reset
//   bus        filter_if slave: sample_end/sample_req/audio_input in,
//              audio_output out
//
// state | meaning
// IDLE  | waiting for sample_end; a new sample is captured here only
// MAC   | accumulating tap r_idx, TAPS cycles
// DONE  | rescale + saturate accumulator into the result register
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int                      TAPS   = TAPS_DEF,
  // Overriding TAPS requires a matching COEFFS table.
  parameter logic [TAPS*COEF_W-1:0]  COEFFS = FILTER_COEFFS
)(
  input  logic     audio_clk,
  input  logic     reset,
  filter_if.slave  bus
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic signed [DATA_W-1:0] r_dly [TAPS];
  logic [IDX_W-1:0]         r_idx;
  logic [DATA_W-1:0]        r_result;
  logic [DATA_W-1:0]        r_out;

  logic                     w_capture;
  logic                     w_mac_en;
  logic                     w_res_we;
  logic signed [DATA_W-1:0] w_tap;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [ACC_W-1:0]  w_acc;

  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // sample_end outside IDLE is dropped on purpose: the delay line must not
  // move under a running accumulation.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_mac_en    = 1'b0;
    w_res_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sample_end) begin
          w_capture   = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_res_we    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_dly[k] <= '0;
      end
    end else if (w_capture) begin
      r_dly[0] <= bus.audio_input;
      for (int k = 1; k < TAPS; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
    end
  end

  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if (w_capture) begin
      r_idx <= '0;
    end else if (w_mac_en) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign w_tap  = r_dly[r_idx];
  assign w_coef = COEFFS[r_idx*COEF_W +: COEF_W];

  filter_mac u_mac (
    .audio_clk (audio_clk),
    .reset     (reset),
    .i_clr     (w_capture),
    .i_en      (w_mac_en),
    .i_sample  (w_tap),
    .i_coef    (w_coef),
    .o_acc     (w_acc)
  );

  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
    end else if (w_res_we) begin
      r_result <= saturate16(w_acc);
    end
  end

  // A request coinciding with the DONE write still sees the old result.
  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
    end else if (bus.sample_req) begin
      r_out <= r_result;
    end
  end

  assign bus.audio_output = r_out;

endmodule

// File: tb/tb_filter_ctrl.sv
module tb_filter_ctrl;
  import filter_pkg::*;

  localparam int N = 8;

  logic        audio_clk = 1'b0;
  logic        reset;
  logic        sample_end;
  logic        sample_req;
  logic [15:0] audio_input;

  always #5 audio_clk = ~audio_clk;

  filter_if bus_a ();
  filter_if bus_b ();

  assign bus_a.sample_end  = sample_end;
  assign bus_a.sample_req  = sample_req;
  assign bus_a.audio_input = audio_input;
  assign bus_b.sample_end  = sample_end;
  assign bus_b.sample_req  = sample_req;
  assign bus_b.audio_input = audio_input;

  // Default moving-average filter.
  filter_ctrl #(.TAPS(N)) u_dut_a (
    .audio_clk (audio_clk),
    .reset     (reset),
    .bus       (bus_a)
  );

  // All-7FFF coefficients so the accumulator can leave the 16-bit range.
  filter_ctrl #(.TAPS(N), .COEFFS({N{16'h7FFF}})) u_dut_b (
    .audio_clk (audio_clk),
    .reset     (reset),
    .bus       (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: history of accepted samples, newest first.
  shortint     hist [N];
  logic [15:0] res_a, res_b, nxt_a, nxt_b, exp_a, exp_b;

  function automatic logic [15:0] sat16(input longint s);
    longint q;
    q = s >>> 15;
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return q[15:0];
  endfunction

  function automatic logic [15:0] fir(input bit use_b);
    longint sum;
    longint coef;
    sum  = 0;
    coef = use_b ? 32767 : 4096;
    for (int k = 0; k < N; k++) begin
      sum += longint'(hist[k]) * coef;
    end
    return sat16(sum);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_a"}, bus_a.audio_output, exp_a);
    check({tag, "_b"}, bus_b.audio_output, exp_b);
  endtask

  task automatic tick();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) hist[k] = 0;
    res_a = '0; res_b = '0; nxt_a = '0; nxt_b = '0; exp_a = '0; exp_b = '0;
  endtask

  task automatic model_accept(input logic [15:0] v);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = shortint'(v);
    nxt_a = fir(1'b0);
    nxt_b = fir(1'b1);
  endtask

  task automatic model_commit();
    res_a = nxt_a;
    res_b = nxt_b;
  endtask

  task automatic pulse_end(input logic [15:0] v);
    sample_end  = 1'b1;
    audio_input = v;
    tick();
    sample_end  = 1'b0;
  endtask

  task automatic pulse_req();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    exp_a = res_a;
    exp_b = res_b;
  endtask

  task automatic step(input logic [15:0] v, input string tag);
    pulse_end(v);
    model_accept(v);
    idle(12);
    model_commit();
    pulse_req();
    check_both(tag);
  endtask

  logic [15:0] v;

  initial begin
    sample_end  = 1'b0;
    sample_req  = 1'b0;
    audio_input = '0;
    reset       = 1'b0;
    model_reset();

    // Reset state
    idle(3);
    check_both("reset");
    reset = 1'b1;
    tick();
    pulse_req();
    check_both("reset_req");

    // Nonzero output, then reset in the middle of a MAC
    step(16'h4000, "pre_reset");
    check("pre_reset_const", bus_a.audio_output, 16'h0800);
    pulse_end(16'h7FFF);
    model_accept(16'h7FFF);
    idle(3);
    reset = 1'b0;
    #1;
    model_reset();
    check_both("reset_mid_mac");
    tick();
    reset = 1'b1;
    idle(15);
    check_both("after_reset_idle");
    pulse_req();
    check_both("req_after_reset");

    // Impulse: 8 outputs of 0FFF, then 0000
    step(16'h7FFF, "impulse");
    check("impulse_const", bus_a.audio_output, 16'h0FFF);
    repeat (8) step(16'h0000, "impulse_tail");
    check("impulse_end_const", bus_a.audio_output, 16'h0000);

    // DC step ramp then steady
    repeat (9) step(16'h4000, "dc_step");
    check("dc_steady_const", bus_a.audio_output, 16'h4000);

    // Negative impulse and truncation toward -inf
    repeat (8) step(16'h0000, "flush1");
    step(16'h8000, "neg_impulse");
    check("neg_impulse_const", bus_a.audio_output, 16'hF000);
    repeat (8) step(16'h0000, "flush2");
    step(16'hFFFF, "trunc_impulse");
    check("trunc_impulse_const", bus_a.audio_output, 16'hFFFF);

    // Saturation on the all-7FFF coefficient instance
    repeat (8) step(16'h7FFF, "sat_pos");
    check("sat_pos_const", bus_b.audio_output, 16'h7FFF);
    repeat (8) step(16'h8000, "sat_neg");
    check("sat_neg_const", bus_b.audio_output, 16'h8000);

    // Random samples
    repeat (24) begin
      v = 16'($urandom_range(0, 65535));
      step(v, "random");
    end

    // Output timing: request at edge N+1 gets old, at N+2 gets new
    v = 16'($urandom_range(0, 65535)) ^ 16'h4000;
    pulse_end(v);
    model_accept(v);
    idle(N);
    pulse_req();
    check_both("req_edge_taps_plus1_old");
    model_commit();
    pulse_req();
    check_both("req_edge_taps_plus2_new");

    // Overrun: second sample_end 3 cycles after the first is dropped
    pulse_end(16'h2000);
    model_accept(16'h2000);
    idle(2);
    pulse_end(16'h7ABC);
    idle(12);
    model_commit();
    pulse_req();
    check_both("overrun_first");
    step(16'h1000, "overrun_next");

    // Coincident sample_end and sample_req
    sample_end  = 1'b1;
    sample_req  = 1'b1;
    audio_input = 16'hC000;
    tick();
    sample_end  = 1'b0;
    sample_req  = 1'b0;
    exp_a = res_a;
    exp_b = res_b;
    model_accept(16'hC000);
    check_both("coincident_old");
    idle(12);
    model_commit();
    pulse_req();
    check_both("coincident_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_ctrl.md
Name: filter_ctrl

Overview:
- Fixed-coefficient FIR low-pass filter for the audio effects path, sitting between the codec sample interface and the effect output mux.
- Each sample_end captures a new 16-bit signed input sample into a delay line and runs a sequential multiply-accumulate (MAC) over all taps.
- The finished result is presented on audio_output at the next sample_req.
- Single clock domain (audio_clk), with no other clock.

Parameters:
- TAPS, 8, number of FIR taps and delay-line depth (2..64).
- COEF_W, 16, coefficient width, signed Q1.15.
- ACC_W, 40, accumulator width, signed.

Ports:
- audio_clk  in  1  sole clock. All logic is rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- sample_end  in  1  one-cycle pulse: audio_input holds a new valid sample.
- sample_req  in  1  one-cycle pulse: the DAC requests the next output sample.
- audio_input  in  16  signed 2's-complement input sample.
- audio_output  out  16  signed filtered sample, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - Delay line cleared to 0; accumulator, result register and audio_output = 16'h0000.
  - FSM goes to IDLE.
  - Reset asserted mid-MAC aborts the computation; no partial result ever reaches audio_output.
- Delay line d[0..TAPS-1], d[0] newest:
  - On sample_end in IDLE: d[0] <= audio_input and d[k] <= d[k-1].
  - Same edge: acc <= 0, idx <= 0, FSM -> MAC.
- MAC state:
  - One tap per cycle: acc <= acc + sign_extend(d[idx] * COEF[idx]), with a 32-bit signed product.
  - idx increments each cycle; after idx = TAPS-1 the FSM goes to DONE (TAPS cycles in MAC).
- DONE state, one cycle:
  - result <= saturate16(acc >>> 15). The shift is arithmetic, with truncation toward negative infinity.
  - Saturation: clamp to 16'h7FFF / 16'h8000.
  - FSM -> IDLE.
- Latency: sample_end at edge 0 gives result valid after edge TAPS+1 (TAPS+2 cycles).
- Output:
  - On sample_req: audio_output <= result, the most recently completed value. Otherwise audio_output holds.
  - A sample_req arriving before a computation completes outputs the previous result.
  - sample_req on the same edge that DONE writes result delivers the old result.
- sample_end while in MAC or DONE: ignored (the sample is dropped, the delay line is untouched). Upstream guarantees spacing ≥ TAPS+2 cycles.
- Simultaneous sample_end and sample_req: both actions occur independently. The output takes the old result; the new computation starts.
- Coefficients are constants (not runtime writable). Default is a moving average: COEF[k] = 16'h1000 (0.125) for all k.

Decomposition:
- Package filter_pkg holds:
  - TAPS default, COEF_W, ACC_W;
  - FILTER_COEFFS constant array (Q1.15);
  - FSM state enum {IDLE, MAC, DONE};
  - saturate16 function.
- One sub-module is natural: filter_mac (signed multiply + accumulate register with clear/enable).
- Delay line, FSM and output register stay in filter_ctrl.

Test Plan:
- Reset: assert reset=0 mid-MAC, release -> audio_output=0000. Next sample_req after idle still gives 0000.
- Impulse: apply sample_end with 7FFF, then 7 samples of 0000, each followed by sample_req after ≥10 cycles -> audio_output=0FFF for 8 consecutive requests, then 0000.
- DC step: feed 4000 for 8 samples -> outputs 0800, 1000, 1800 … 4000, then steady 4000.
- Negative/truncation: impulse 8000 -> output F000. Impulse FFFF -> FFFF (truncation toward -inf).
- Saturation (override FILTER_COEFFS all 7FFF): feed 7FFF for 8 samples -> output 7FFF. Feed 8000 for 8 samples -> output 8000.
- Timing/overrun:
  - sample_req at cycle TAPS+1 after sample_end -> old value.
  - sample_req at TAPS+2 -> new value.
  - A second sample_end 3 cycles after the first is dropped (delay line unchanged).
  - Coincident sample_end+sample_req -> output = previous result.
